execute_branch_unit: RTL and testbench
======================================

Name: execute_branch_unit

Overview:
- Execute stage directly downstream of the instruction decoder.
- Consumes the decoder's registered one-hot operation flags (beq, bne, blt, bge, bltu, bgeu, addi, add), imm and rd, together with register-file read data and the instruction PC.
- Resolves conditional branches and computes add/addi results for writeback.
- Generates the jump_branch_enable flush request that the decoder and fetch use to squash wrong-path instructions, holding it for a parameterised number of cycles.

Parameters:
FLUSH_CYCLES, 2, consecutive cycles jump_branch_enable stays high after a taken branch; legal range 1..15.

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
beq, bne, blt, bge, bltu, bgeu, addi, add  input  1 each  decoded operation flags, one-hot or all-zero
imm  input  32  sign-extended immediate from decode
rd  input  5  destination register index
rs1_data  input  32  register-file data for rs1, aligned with the flags
rs2_data  input  32  register-file data for rs2, aligned with the flags
pc  input  32  address of the instruction whose flags are present
jump_branch_enable  output  1  flush/redirect request to decode and fetch
jump_target  output  32  redirect address, valid while jump_branch_enable=1
wb_enable  output  1  register-file write strobe
wb_rd  output  5  write index
wb_data  output  32  write data
retire_count  output  32  count of executed (non-squashed) instructions

Behaviour:
- Reset: clk and reset_n (asynchronous, active-low) as already decided. Assertion takes effect immediately, including mid-flush. All outputs go to 0, state goes to RUN, the flush counter clears.
- Sampling: inputs are sampled on each posedge clk. All outputs are registered, so results appear one cycle after the sampling edge.
- Valid instruction: exactly one flag set. Zero flags = bubble. More than one flag = illegal; treated as a bubble with no writeback, no branch and no count.
- Squash rule: any instruction sampled on an edge where jump_branch_enable is already 1 is treated as a bubble.
- add: wb_data = rs1_data + rs2_data, modulo 2^32.
- addi: wb_data = rs1_data + imm, modulo 2^32.
- Writeback gating:
  - wb_enable=1 for exactly one cycle only if rd != 0.
  - rd == 0: wb_enable stays 0, but the instruction still counts as retired.
  - wb_rd and wb_data update only on an actual writeback; otherwise they hold their previous values.
- Branch conditions:
  - beq: rs1_data == rs2_data
  - bne: rs1_data != rs2_data
  - blt: signed <
  - bge: signed >=
  - bltu: unsigned <
  - bgeu: unsigned >=
- Target: jump_target = (pc + imm) with bit 0 forced to 0, modulo 2^32 (wraps). It updates only on a taken branch and holds otherwise.
- Branches never write back. Taken and not-taken branches both count as retired.
- State machine:
  - RUN: a taken branch sets jump_branch_enable=1, loads the flush counter with FLUSH_CYCLES-1 and moves to FLUSH. Otherwise jump_branch_enable=0.
  - FLUSH: jump_branch_enable=1. All inputs are squashed.
    - Counter == 0 → return to RUN, with jump_branch_enable=0 on the next cycle.
    - Otherwise the counter decrements.
  - Net effect: jump_branch_enable is high for exactly FLUSH_CYCLES consecutive cycles. Branches sampled during FLUSH are ignored, so there is no re-trigger or extension.
- retire_count increments by 1 per valid, non-squashed instruction and wraps from 0xFFFFFFFF to 0.
- Simultaneous events: the last FLUSH cycle and a new instruction arriving on the RUN-return edge are separate. The instruction sampled while jump_branch_enable is still 1 is squashed. The next edge executes normally and may start a new flush back-to-back.

Test Plan:
1. add, rs1_data=5, rs2_data=7, rd=3 → next cycle: wb_enable=1 for one cycle, wb_rd=3, wb_data=12, retire_count=1.
2. addi, rd=0, rs1_data=5, imm=1 → wb_enable stays 0, wb_rd/wb_data unchanged, retire_count increments.
3. Same operands, two branch types: rs1_data=0xFFFFFFFF, rs2_data=1, pc=0x100, imm=0xFFFFFFF0.
   - blt → jump_branch_enable high exactly 2 cycles, jump_target=0xF0.
   - bltu → not taken, jump_branch_enable stays 0, retire_count still increments.
4. Taken beq (rs1_data=rs2_data=9) followed by add (rd=4) on each of the next three edges:
   - Only the third add produces wb_enable=1.
   - retire_count rises by exactly 2 over the sequence.
   - A second beq presented during FLUSH does not extend the flush.
5. beq and add asserted together, or addi with bne → no writeback, no redirect, retire_count unchanged.
6. reset_n pulsed low during the first FLUSH cycle → all outputs 0 immediately. After release, an add (rs1_data=1, rs2_data=2, rd=1) executes on the first edge: wb_data=3.

Source files
------------

// File: rtl/execute_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : execute_branch_unit
// Description : Execute stage behind the decoder. Resolves conditional
//               branches, computes add/addi writeback results, counts
//               retired instructions and holds the jump_branch_enable flush
//               request high for FLUSH_CYCLES cycles after a taken branch.
// Revision    : 1.0 - initial release
// ============================================================================
module execute_branch_unit #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        beq,
    input  logic        bne,
    input  logic        blt,
    input  logic        bge,
    input  logic        bltu,
    input  logic        bgeu,
    input  logic        addi,
    input  logic        add,
    input  logic [31:0] imm,
    input  logic [4:0]  rd,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] pc,
    output logic        jump_branch_enable,
    output logic [31:0] jump_target,
    output logic        wb_enable,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [31:0] retire_count
);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  flush_cnt_q, flush_cnt_d;
    logic        jbe_q, jbe_d;
    logic [31:0] target_q, target_d;
    logic        wb_en_q, wb_en_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [31:0] retire_q, retire_d;

    logic [7:0]  flags;
    logic        valid_op;
    logic        execute;
    logic        is_alu;
    logic        taken;
    logic [31:0] alu_result;

    assign flags = {beq, bne, blt, bge, bltu, bgeu, addi, add};

    // Decode: exactly one flag is a real instruction; anything sampled while
    // the flush request is already high belongs to the wrong path.
    always_comb begin
        valid_op   = $onehot(flags);
        execute    = valid_op && !jbe_q;
        is_alu     = add | addi;
        alu_result = add ? (rs1_data + rs2_data) : (rs1_data + imm);
        taken      = (beq  && (rs1_data == rs2_data))
                  || (bne  && (rs1_data != rs2_data))
                  || (blt  && ($signed(rs1_data) <  $signed(rs2_data)))
                  || (bge  && ($signed(rs1_data) >= $signed(rs2_data)))
                  || (bltu && (rs1_data <  rs2_data))
                  || (bgeu && (rs1_data >= rs2_data));
    end

    // Next-state computation for the flush FSM, writeback and retire count.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        jbe_d       = jbe_q;
        target_d    = target_q;
        wb_en_d     = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        retire_d    = retire_q;

        case (state_q)
            RUN: begin
                jbe_d = 1'b0;
                if (execute && taken) begin
                    jbe_d       = 1'b1;
                    flush_cnt_d = FLUSH_LOAD;
                    state_d     = FLUSH;
                    target_d    = (pc + imm) & 32'hFFFF_FFFE;
                end
            end
            FLUSH: begin
                // Every input is squashed here, so a branch cannot re-arm.
                if (flush_cnt_q == 4'd0) begin
                    state_d = RUN;
                    jbe_d   = 1'b0;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                    jbe_d       = 1'b1;
                end
            end
            default: begin
                state_d = RUN;
                jbe_d   = 1'b0;
            end
        endcase

        // rd == 0 still retires but never strobes the register file.
        if (execute && is_alu && (rd != 5'd0)) begin
            wb_en_d   = 1'b1;
            wb_rd_d   = rd;
            wb_data_d = alu_result;
        end

        if (execute) begin
            retire_d = retire_q + 32'd1;
        end
    end

    // State and output registers; reset acts immediately, even mid-flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RUN;
            flush_cnt_q <= 4'd0;
            jbe_q       <= 1'b0;
            target_q    <= 32'd0;
            wb_en_q     <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= 32'd0;
            retire_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            jbe_q       <= jbe_d;
            target_q    <= target_d;
            wb_en_q     <= wb_en_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            retire_q    <= retire_d;
        end
    end

    assign jump_branch_enable = jbe_q;
    assign jump_target        = target_q;
    assign wb_enable          = wb_en_q;
    assign wb_rd              = wb_rd_q;
    assign wb_data            = wb_data_q;
    assign retire_count       = retire_q;

endmodule
`default_nettype wire

// File: tb/tb_execute_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_execute_branch_unit
// Description : Self-checking bench for execute_branch_unit: directed
//               scenarios followed by random instruction streams compared
//               against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_branch_unit;

    localparam int FLUSH_CYCLES = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        beq, bne, blt, bge, bltu, bgeu, addi, add;
    logic [31:0] imm, rs1_data, rs2_data, pc;
    logic [4:0]  rd;

    logic        jump_branch_enable;
    logic [31:0] jump_target;
    logic        wb_enable;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] retire_count;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    int          m_flush_left;
    logic [31:0] m_target;
    logic        m_wb_en;
    logic [4:0]  m_wb_rd;
    logic [31:0] m_wb_data;
    logic [31:0] m_retire;

    execute_branch_unit #(.FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .beq                (beq),
        .bne                (bne),
        .blt                (blt),
        .bge                (bge),
        .bltu               (bltu),
        .bgeu               (bgeu),
        .addi               (addi),
        .add                (add),
        .imm                (imm),
        .rd                 (rd),
        .rs1_data           (rs1_data),
        .rs2_data           (rs2_data),
        .pc                 (pc),
        .jump_branch_enable (jump_branch_enable),
        .jump_target        (jump_target),
        .wb_enable          (wb_enable),
        .wb_rd              (wb_rd),
        .wb_data            (wb_data),
        .retire_count       (retire_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_flush_left = 0;
        m_target     = 32'd0;
        m_wb_en      = 1'b0;
        m_wb_rd      = 5'd0;
        m_wb_data    = 32'd0;
        m_retire     = 32'd0;
    endtask

    // One clock edge of the architectural behaviour, from the rules directly.
    task automatic model_edge();
        int  n;
        logic t;
        n = int'(beq) + int'(bne) + int'(blt) + int'(bge)
          + int'(bltu) + int'(bgeu) + int'(addi) + int'(add);
        m_wb_en = 1'b0;
        if (m_flush_left > 0) begin
            m_flush_left = m_flush_left - 1;
        end else if (n == 1) begin
            m_retire = m_retire + 32'd1;
            if (add || addi) begin
                if (rd != 5'd0) begin
                    m_wb_en   = 1'b1;
                    m_wb_rd   = rd;
                    m_wb_data = add ? rs1_data + rs2_data : rs1_data + imm;
                end
            end else begin
                if (beq)       t = (rs1_data == rs2_data);
                else if (bne)  t = (rs1_data != rs2_data);
                else if (blt)  t = ($signed(rs1_data) <  $signed(rs2_data));
                else if (bge)  t = ($signed(rs1_data) >= $signed(rs2_data));
                else if (bltu) t = (rs1_data <  rs2_data);
                else           t = (rs1_data >= rs2_data);
                if (t) begin
                    m_flush_left = FLUSH_CYCLES;
                    m_target     = (pc + imm) & 32'hFFFF_FFFE;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_jbe"},    {31'd0, jump_branch_enable}, {31'd0, (m_flush_left > 0)});
        chk({tag, "_target"}, jump_target, m_target);
        chk({tag, "_wb_en"},  {31'd0, wb_enable}, {31'd0, m_wb_en});
        chk({tag, "_wb_rd"},  {27'd0, wb_rd}, {27'd0, m_wb_rd});
        chk({tag, "_wb_data"}, wb_data, m_wb_data);
        chk({tag, "_retire"}, retire_count, m_retire);
    endtask

    task automatic drive(input logic [7:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic [4:0] r, input logic [31:0] p);
        {beq, bne, blt, bge, bltu, bgeu, addi, add} = f;
        rs1_data = a;
        rs2_data = b;
        imm      = im;
        rd       = r;
        pc       = p;
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    localparam logic [7:0] F_BEQ  = 8'b1000_0000;
    localparam logic [7:0] F_BNE  = 8'b0100_0000;
    localparam logic [7:0] F_BLT  = 8'b0010_0000;
    localparam logic [7:0] F_BLTU = 8'b0000_1000;
    localparam logic [7:0] F_ADDI = 8'b0000_0010;
    localparam logic [7:0] F_ADD  = 8'b0000_0001;
    localparam logic [7:0] F_NONE = 8'b0000_0000;

    initial begin
        logic [31:0] base;
        model_reset();
        drive(F_NONE, 0, 0, 0, 0, 0);

        // Reset state
        #2;
        check_all("reset");
        #10 reset_n = 1'b1;

        // add 5+7 -> x3
        drive(F_ADD, 32'd5, 32'd7, 32'd0, 5'd3, 32'h40);
        cycle("tp1");
        chk("tp1_wb_data_const", wb_data, 32'd12);
        chk("tp1_wb_en_const", {31'd0, wb_enable}, 32'd1);
        chk("tp1_retire_const", retire_count, 32'd1);
        drive(F_NONE, 0, 0, 0, 0, 0);
        cycle("tp1_pulse");
        chk("tp1_wb_en_one_cycle", {31'd0, wb_enable}, 32'd0);

        // addi to x0 retires without writeback
        drive(F_ADDI, 32'd5, 32'd0, 32'd1, 5'd0, 32'h44);
        cycle("tp2");
        chk("tp2_wb_data_hold", wb_data, 32'd12);
        chk("tp2_retire_const", retire_count, 32'd2);

        // blt taken (-1 < 1), target wraps to 0xF0
        drive(F_BLT, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF0, 5'd0, 32'h100);
        cycle("tp3_blt");
        chk("tp3_target_const", jump_target, 32'h0000_00F0);
        drive(F_NONE, 0, 0, 0, 0, 0);
        cycle("tp3_f1");
        chk("tp3_jbe_2nd", {31'd0, jump_branch_enable}, 32'd1);
        cycle("tp3_f2");
        chk("tp3_jbe_drop", {31'd0, jump_branch_enable}, 32'd0);
        base = retire_count;
        drive(F_BLTU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF0, 5'd0, 32'h100);
        cycle("tp3_bltu");
        chk("tp3_bltu_jbe", {31'd0, jump_branch_enable}, 32'd0);
        chk("tp3_bltu_retire", retire_count, base + 32'd1);

        // taken beq then add on three edges, second beq inside flush
        base = retire_count;
        drive(F_BEQ, 32'd9, 32'd9, 32'h20, 5'd0, 32'h200);
        cycle("tp4_beq");
        drive(F_BEQ, 32'd9, 32'd9, 32'h80, 5'd0, 32'h204);
        cycle("tp4_beq2");
        drive(F_ADD, 32'd1, 32'd1, 32'd0, 5'd4, 32'h208);
        cycle("tp4_add1");
        chk("tp4_add1_wb_en", {31'd0, wb_enable}, 32'd0);
        cycle("tp4_add2");
        chk("tp4_add2_wb_en", {31'd0, wb_enable}, 32'd1);
        chk("tp4_retire_delta", retire_count, base + 32'd2);
        chk("tp4_target_kept", jump_target, 32'h220);

        // illegal multi-flag combinations
        base = retire_count;
        drive(F_BEQ | F_ADD, 32'd3, 32'd3, 32'd0, 5'd7, 32'h300);
        cycle("tp5_a");
        drive(F_ADDI | F_BNE, 32'd3, 32'd4, 32'd8, 5'd7, 32'h304);
        cycle("tp5_b");
        chk("tp5_retire_same", retire_count, base);
        chk("tp5_no_redirect", {31'd0, jump_branch_enable}, 32'd0);

        // pc + imm wrap with odd sum: bit 0 cleared
        drive(F_BEQ, 32'd0, 32'd0, 32'h21, 5'd0, 32'hFFFF_FFF0);
        cycle("wrap");
        chk("wrap_target_const", jump_target, 32'h0000_0010);

        // reset pulsed during the first flush cycle
        drive(F_NONE, 0, 0, 0, 0, 0);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all("tp6_reset");
        #2 reset_n = 1'b1;
        drive(F_ADD, 32'd1, 32'd2, 32'd0, 5'd1, 32'h0);
        cycle("tp6_add");
        chk("tp6_wb_data_const", wb_data, 32'd3);

        // random instruction streams
        for (int i = 0; i < 400; i++) begin
            logic [7:0]  f;
            logic [31:0] a, b;
            int          sel;
            sel = $urandom_range(0, 9);
            if (sel < 8)       f = 8'd1 << sel;
            else if (sel == 8) f = 8'd0;
            else               f = 8'($urandom);
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            drive(f, a, b, $urandom, 5'($urandom_range(0, 31)), $urandom);
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
